// File: rtl/lut_neuron_table_writer_if.sv
// Configuration-stream and lookup bus for the run-time programmable LUT neuron.
// master: configuration loader / layer datapath side; slave: the table writer.
interface lut_neuron_table_writer_if #(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 2
);
    logic                cfg_start;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [OUT_BITS-1:0] cfg_data;
    logic                cfg_last;
    logic                cfg_error;
    logic                table_valid;
    logic                in_valid;
    logic [IN_BITS-1:0]  M0;
    logic                out_valid;
    logic [OUT_BITS-1:0] M1;

    modport master (
        output cfg_start, cfg_valid, cfg_data, cfg_last, in_valid, M0,
        input  cfg_ready, cfg_error, table_valid, out_valid, M1
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data, cfg_last, in_valid, M0,
        output cfg_ready, cfg_error, table_valid, out_valid, M1
    );
endinterface

// File: rtl/lut_neuron_table_writer.sv
// Run-time programmable LogicNet neuron: the 2^IN_BITS x OUT_BITS truth table is
// streamed in over a valid/ready config port and then served as a registered,
// fully pipelined lookup (latency 1).
module lut_neuron_table_writer #(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 2
) (
    input logic                     clk,
    input logic                     rst_n,
    lut_neuron_table_writer_if.slave bus
);
    localparam int DEPTH = 2 ** IN_BITS;
    localparam int AW    = IN_BITS + 1;

    typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_READY} state_t;

    state_t              state, state_nxt;
    logic [AW-1:0]       wr_addr, wr_addr_nxt;
    logic                err, err_nxt;
    logic                wr_en;
    logic                at_end;
    logic                lookup_en;
    logic [OUT_BITS-1:0] mem [DEPTH];
    logic                vld_p1;
    logic [OUT_BITS-1:0] m1_p1;

    assign at_end    = (wr_addr == AW'(DEPTH - 1));
    assign lookup_en = bus.in_valid && (state == S_READY);

    // Control registers: load state, write pointer and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_EMPTY;
            wr_addr <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            wr_addr <= wr_addr_nxt;
            err     <= err_nxt;
        end
    end

    // Next-state logic; cfg_start always restarts a load and suppresses that cycle's write.
    always_comb begin
        state_nxt   = state;
        wr_addr_nxt = wr_addr;
        err_nxt     = err;
        wr_en       = 1'b0;
        if (bus.cfg_start) begin
            state_nxt   = S_LOAD;
            wr_addr_nxt = '0;
            err_nxt     = 1'b0;
        end else if (state == S_LOAD && bus.cfg_valid) begin
            wr_en       = 1'b1;
            wr_addr_nxt = wr_addr + 1'b1;
            if (at_end) begin
                if (bus.cfg_last) begin
                    state_nxt = S_READY;
                end else begin
                    state_nxt = S_EMPTY;
                    err_nxt   = 1'b1;
                end
            end else if (bus.cfg_last) begin
                state_nxt = S_EMPTY;
                err_nxt   = 1'b1;
            end
        end
    end

    // Table storage: written only by accepted config words, never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr[IN_BITS-1:0]] <= bus.cfg_data;
        end
    end

    // ---- stage p1: registered lookup; result holds when no lookup is served ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            m1_p1  <= '0;
        end else begin
            vld_p1 <= lookup_en;
            if (lookup_en) begin
                m1_p1 <= mem[bus.M0];
            end
        end
    end

    assign bus.cfg_ready   = (state == S_LOAD);
    assign bus.cfg_error   = err;
    assign bus.table_valid = (state == S_READY);
    assign bus.out_valid   = vld_p1;
    assign bus.M1          = m1_p1;
endmodule

// File: tb/tb_lut_neuron_table_writer.sv
// Self-checking bench for lut_neuron_table_writer: scoreboard of expected lookup
// results plus status-flag checks around loads, errors, restarts and reset.
module tb_lut_neuron_table_writer;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   tests  = 0;
    int   failed = 0;

    logic [1:0] model [64];
    logic [1:0] sb_q [$];

    lut_neuron_table_writer_if #(.IN_BITS(6), .OUT_BITS(2)) bus ();

    lut_neuron_table_writer #(.IN_BITS(6), .OUT_BITS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] pat(input int mode, input int k);
        if (mode == 0) return 2'(k % 4);
        if (mode == 1) return 2'b11;
        return 2'b00;
    endfunction

    // Stream n words without a cfg_start; cfg_last on index last_at (-1: never).
    task automatic stream(input int n, input int mode, input int last_at, input bit probe_last);
        for (int k = 0; k < n; k++) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_data  = pat(mode, k);
            bus.cfg_last  = (k == last_at);
            if (probe_last && k == last_at) begin
                bus.in_valid = 1'b1;
                bus.M0       = 6'd0;
            end
            if (k < 64) model[k] = pat(mode, k);
            tick();
            bus.in_valid = 1'b0;
        end
        bus.cfg_valid = 1'b0;
        bus.cfg_last  = 1'b0;
    endtask

    task automatic load(input int n, input int mode, input int last_at, input bit probe_last);
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        stream(n, mode, last_at, probe_last);
    endtask

    task automatic lookup(input logic [5:0] a);
        bus.in_valid = 1'b1;
        bus.M0       = a;
        sb_q.push_back(model[a]);
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Scoreboard monitor: every out_valid pulse must match the oldest expected result.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_out_valid", 32'(bus.M1), 32'hDEAD);
                end else begin
                    check_eq("lookup_M1", 32'(bus.M1), 32'(sb_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cfg_start = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = '0;
        bus.cfg_last  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.M0        = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cfg_ready", 32'(bus.cfg_ready), 0);
        check_eq("rst_cfg_error", 32'(bus.cfg_error), 0);
        check_eq("rst_table_valid", 32'(bus.table_valid), 0);
        check_eq("rst_out_valid", 32'(bus.out_valid), 0);
        check_eq("rst_M1", 32'(bus.M1), 0);
        rst_n = 1'b1;

        // Full load k mod 4, then single lookup
        load(64, 0, 63, 1'b0);
        @(negedge clk);
        check_eq("full_table_valid", 32'(bus.table_valid), 1);
        check_eq("full_cfg_error", 32'(bus.cfg_error), 0);
        check_eq("full_cfg_ready", 32'(bus.cfg_ready), 0);
        lookup(6'd13);
        @(negedge clk);
        check_eq("lookup13_out_valid", 32'(bus.out_valid), 1);

        // Back-to-back lookups
        lookup(6'd0);
        lookup(6'd1);
        lookup(6'd2);
        lookup(6'd63);
        @(negedge clk);
        check_eq("b2b_drained", 32'(sb_q.size()), 0);
        @(negedge clk);
        check_eq("b2b_out_valid_low", 32'(bus.out_valid), 0);

        // Short load: cfg_last on the 10th word
        load(10, 0, 9, 1'b0);
        @(negedge clk);
        check_eq("short_cfg_error", 32'(bus.cfg_error), 1);
        check_eq("short_table_valid", 32'(bus.table_valid), 0);
        check_eq("short_cfg_ready", 32'(bus.cfg_ready), 0);
        bus.in_valid = 1'b1;
        bus.M0       = 6'd5;
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_eq("short_lookup_out_valid", 32'(bus.out_valid), 0);
        check_eq("short_lookup_M1_held", 32'(bus.M1), 3);
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        @(negedge clk);
        check_eq("start_clears_error", 32'(bus.cfg_error), 0);
        check_eq("start_cfg_ready", 32'(bus.cfg_ready), 1);

        // Missing last: 64 words without cfg_last
        stream(63, 0, -1, 1'b0);
        check_eq("nolast_err_before_64th", 32'(bus.cfg_error), 0);
        stream(1, 0, -1, 1'b0);
        @(negedge clk);
        check_eq("nolast_cfg_error", 32'(bus.cfg_error), 1);
        check_eq("nolast_table_valid", 32'(bus.table_valid), 0);
        check_eq("nolast_cfg_ready", 32'(bus.cfg_ready), 0);

        // Reload; a lookup on the final-accept cycle must not be served
        load(64, 0, 63, 1'b1);
        @(negedge clk);
        check_eq("reload_table_valid", 32'(bus.table_valid), 1);

        // cfg_start together with a lookup: old table serves it
        bus.cfg_start = 1'b1;
        bus.in_valid  = 1'b1;
        bus.M0        = 6'd3;
        sb_q.push_back(model[3]);
        tick();
        bus.cfg_start = 1'b0;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        check_eq("start_lookup_out_valid", 32'(bus.out_valid), 1);
        check_eq("start_drops_table_valid", 32'(bus.table_valid), 0);

        // Partial load, restart with cfg_valid high (no write), then all-11 load
        stream(5, 2, -1, 1'b0);
        bus.cfg_start = 1'b1;
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 2'b01;
        tick();
        bus.cfg_start = 1'b0;
        stream(64, 1, 63, 1'b0);
        @(negedge clk);
        check_eq("all3_table_valid", 32'(bus.table_valid), 1);
        check_eq("all3_cfg_error", 32'(bus.cfg_error), 0);
        lookup(6'd3);
        lookup(6'd0);
        @(negedge clk);
        check_eq("all3_drained", 32'(sb_q.size()), 0);

        // Asynchronous reset in the middle of a load
        load(30, 0, -1, 1'b0);
        bus.cfg_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_cfg_ready", 32'(bus.cfg_ready), 0);
        check_eq("arst_cfg_error", 32'(bus.cfg_error), 0);
        check_eq("arst_table_valid", 32'(bus.table_valid), 0);
        check_eq("arst_out_valid", 32'(bus.out_valid), 0);
        check_eq("arst_M1", 32'(bus.M1), 0);
        bus.cfg_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_data  = 2'b10;
            @(negedge clk);
            check_eq("post_rst_no_ready", 32'(bus.cfg_ready), 0);
            check_eq("post_rst_no_error", 32'(bus.cfg_error), 0);
            tick();
        end
        bus.cfg_valid = 1'b0;
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        @(negedge clk);
        check_eq("post_rst_start_ready", 32'(bus.cfg_ready), 1);
        check_eq("post_rst_table_valid", 32'(bus.table_valid), 0);
        check_eq("sb_empty_at_end", 32'(sb_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/lut_neuron_table_writer.md
Name: lut_neuron_table_writer

Overview:
- Run-time-programmable counterpart to the generated fixed-ROM LogicNet neurons. The neuron's 2^IN_BITS x OUT_BITS truth table is written over a valid/ready configuration stream, then served to the layer datapath as a registered lookup.
- Sits between the configuration loader (which streams truth tables exported by training) and the layer input/output buses. A new network can be loaded without re-synthesis.

Parameters:
- IN_BITS, 6, neuron input (fan-in x activation) width; table depth DEPTH = 2**IN_BITS (derived, not overridable).
- OUT_BITS, 2, neuron output activation width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  single-cycle pulse: invalidate the table and begin a load at address 0.
- cfg_valid  in  1  configuration word valid.
- cfg_ready  out  1  configuration word accepted this cycle when cfg_valid && cfg_ready.
- cfg_data  in  OUT_BITS  table entry for the current write address.
- cfg_last  in  1  marks the final entry (address DEPTH-1).
- cfg_error  out  1  sticky load-error flag; cleared by the next cfg_start.
- table_valid  out  1  table fully loaded; lookups enabled.
- in_valid  in  1  lookup request.
- M0  in  IN_BITS  lookup address (neuron input vector; M0[0] = address LSB).
- out_valid  out  1  lookup result valid.
- M1  out  OUT_BITS  lookup result.

Behaviour:
- Reset (async assert, sync release): state EMPTY; cfg_ready=0, cfg_error=0, table_valid=0, out_valid=0, M1=0, wr_addr=0. Table contents are not reset and are don't-care until loaded.
- States:
  - EMPTY: cfg_ready=0. cfg_start -> LOAD, wr_addr=0, cfg_error=0.
  - LOAD: cfg_ready=1. Each accepted word writes mem[wr_addr]=cfg_data, then wr_addr++.
    - Accepted word with wr_addr==DEPTH-1 and cfg_last=1 -> READY; table_valid=1 from the next cycle.
    - Accepted word with cfg_last=1 and wr_addr<DEPTH-1 (short load) -> EMPTY, cfg_error=1; the write still occurs.
    - Accepted word with wr_addr==DEPTH-1 and cfg_last=0 (missing last) -> EMPTY, cfg_error=1.
    - cfg_start while in LOAD -> restart: wr_addr=0, no write that cycle, even if cfg_valid=1.
  - READY: cfg_ready=0; lookups served. cfg_start -> LOAD, table_valid=0 the next cycle.
- cfg_valid while cfg_ready=0 is ignored, with no error.
- Lookup:
  - Registered, latency 1. in_valid sampled at edge N while table_valid=1 -> at edge N+1, out_valid=1 and M1=mem[M0 sampled at N].
  - Fully pipelined: one lookup per cycle, back-to-back.
  - in_valid with table_valid=0 -> out_valid=0 next cycle; M1 holds its previous value.
  - out_valid is a pulse per request. There is no backpressure on the output side.
- Simultaneous events:
  - cfg_start in READY together with in_valid: the lookup is served from the old table (out_valid=1 next cycle), then table_valid drops.
  - A lookup issued on the same cycle as the final cfg_last acceptance is NOT served (table_valid still 0).
- wr_addr is IN_BITS+1 wide internally; it never wraps past DEPTH-1 because terminal-address handling exits LOAD.
- Asynchronous reset mid-load: returns to EMPTY, table_valid=0, cfg_error=0. Partial contents are discarded logically; a full reload is required.
- Memory: DEPTH x OUT_BITS distributed RAM, one write port (config), one read port (lookup), both synchronous to clk.

Test Plan:
- Reset, then a full load of entries mem[k]=k mod 4 for k=0..63 with cfg_last on k=63 -> table_valid=1 one cycle after the last accept; cfg_error=0. Then in_valid with M0=6'd13 -> next cycle out_valid=1, M1=2'b01.
- Back-to-back lookups M0=0,1,2,63 on consecutive cycles -> out_valid high 4 cycles, M1=00,01,10,11 in order, one cycle delayed.
- Load 10 words with cfg_last on the 10th -> cfg_error=1, state EMPTY. A lookup with M0=5 -> out_valid stays 0. A subsequent cfg_start clears cfg_error.
- Load 64 words with cfg_last never asserted -> cfg_error=1 after the 64th accept, table_valid=0.
- In READY, assert cfg_start and in_valid(M0=6'd3) together -> out_valid=1, M1=old mem[3]; table_valid=0 next cycle. Reload with all-2'b11 -> lookup M0=3 returns 2'b11.
- Drop rst_n after 30 of 64 words -> all outputs zero immediately. After release, cfg_valid pulses get no cfg_ready until cfg_start.
